// File: rtl/mem_bus_bridge.sv
// Bridge from the CPU native memory bus to a 2 KiB RAM window and a 6-bit LED register.
// Optional feature macro: MEM_BUS_ERR_TRAP_EN (unmapped accesses return 32'hDEAD_BEEF and set sticky bus_err).
module mem_bus_bridge #(
  parameter logic [31:0] RAM_BASE = 32'h0000_0000,
  parameter logic [31:0] LED_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        ram_sel,
  output logic [3:0]  ram_wen,
  output logic [10:0] ram_address,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [5:0]  led,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

`ifdef MEM_BUS_ERR_TRAP_EN
  localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] UNMAPPED_DATA = 32'h0000_0000;
`endif

  state_t      state;
  logic [10:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic        is_ram_r;
  logic        is_led_r;
  logic        hit_ram;
  logic        hit_led;
  logic        unused_ok;

  // RAM takes priority should the LED word ever be placed inside the window.
  assign hit_ram = (mem_addr[31:11] == RAM_BASE[31:11]);
  assign hit_led = !hit_ram && (mem_addr[31:2] == LED_ADDR[31:2]);

  assign ram_address = addr_r;
  assign ram_wdata   = wdata_r;
  assign unused_ok   = &{1'b0, mem_instr};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      addr_r    <= 11'd0;
      wdata_r   <= 32'd0;
      wstrb_r   <= 4'd0;
      is_ram_r  <= 1'b0;
      is_led_r  <= 1'b0;
      ram_sel   <= 1'b0;
      ram_wen   <= 4'd0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
      led       <= 6'd0;
`ifdef MEM_BUS_ERR_TRAP_EN
      bus_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          if (mem_valid) begin
            addr_r   <= mem_addr[10:0];
            wdata_r  <= mem_wdata;
            wstrb_r  <= mem_wstrb;
            is_ram_r <= hit_ram;
            is_led_r <= hit_led;
            ram_sel  <= hit_ram;
            ram_wen  <= hit_ram ? mem_wstrb : 4'd0;
            state    <= ACCESS;
          end else begin
            ram_sel <= 1'b0;
            ram_wen <= 4'd0;
          end
        end
        ACCESS: begin
          // The RAM write lands on this edge; the read data is captured alongside it.
          ram_sel   <= 1'b0;
          ram_wen   <= 4'd0;
          mem_ready <= 1'b1;
          state     <= RESP;
          if (is_ram_r) begin
            mem_rdata <= ram_rdata;
          end else if (is_led_r) begin
            mem_rdata <= {26'd0, led};
            if (wstrb_r[0]) begin
              led <= wdata_r[5:0];
            end else begin
              led <= led;
            end
          end else begin
            mem_rdata <= UNMAPPED_DATA;
`ifdef MEM_BUS_ERR_TRAP_EN
            bus_err   <= 1'b1;
`endif
          end
        end
        RESP: begin
          mem_ready <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          ram_sel   <= 1'b0;
          ram_wen   <= 4'd0;
          mem_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifndef MEM_BUS_ERR_TRAP_EN
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Scoreboard bench for mem_bus_bridge: driver pushes expected read data, a monitor pops on mem_ready.
module tb_mem_bus_bridge;
  localparam logic [31:0] RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] LED_ADDR = 32'h8000_0000;
`ifdef MEM_BUS_ERR_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [3:0]  mem_wstrb = 4'd0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        ram_sel;
  logic [3:0]  ram_wen;
  logic [10:0] ram_address;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [5:0]  led;
  logic        bus_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          chk;
    logic [31:0] data;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  logic [31:0] ref_mem [0:511];
  logic [5:0]  ref_led;
  bit          ref_err;

  // RAM device seen by the bridge
  logic [31:0] ram_dev [0:511];

  always #5 clk = ~clk;

  mem_bus_bridge #(.RAM_BASE(RAM_BASE), .LED_ADDR(LED_ADDR)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .ram_sel(ram_sel),
    .ram_wen(ram_wen), .ram_address(ram_address), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .led(led), .bus_err(bus_err)
  );

  assign ram_rdata = ram_dev[ram_address[10:2]];

  always @(posedge clk) begin
    if (ram_sel) begin
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) ram_dev[ram_address[10:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endfunction

  // Monitor: compare read data whenever the bridge signals completion.
  initial begin
    bit   prev_rdy;
    exp_t e;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_rdy = 1'b0;
      end else begin
        if (mem_ready) begin
          if (prev_rdy) check("ready_width", 32'd1, 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_ready", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            if (e.chk) check(e.name, mem_rdata, e.data);
          end
        end
        prev_rdy = mem_ready;
      end
    end
  end

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    if (a[31:11] == RAM_BASE[31:11]) return ref_mem[a[10:2]];
    if (a[31:2] == LED_ADDR[31:2]) return {26'd0, ref_led};
    return TRAP ? 32'hDEAD_BEEF : 32'h0000_0000;
  endfunction

  function automatic void model_apply(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    if (a[31:11] == RAM_BASE[31:11]) begin
      for (int b = 0; b < 4; b++)
        if (ws[b]) ref_mem[a[10:2]][8*b +: 8] = wd[8*b +: 8];
    end else if (a[31:2] == LED_ADDR[31:2]) begin
      if (ws[0]) ref_led = wd[5:0];
    end else begin
      ref_err = TRAP;
    end
  endfunction

  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input string nm);
    exp_t e;
    int   cnt;
    bit   is_ram;
    is_ram = (a[31:11] == RAM_BASE[31:11]);
    e.chk = (ws == 4'd0);
    e.data = model_rdata(a);
    e.name = nm;
    exp_q.push_back(e);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    @(posedge clk); #1;
    mem_valid = $urandom_range(0, 1) == 1;
    if (is_ram) begin
      check({nm, "_ram_sel"}, {31'd0, ram_sel}, 32'd1);
      check({nm, "_ram_address"}, {21'd0, ram_address}, {21'd0, a[10:0]});
      check({nm, "_ram_wen"}, {28'd0, ram_wen}, {28'd0, ws});
    end else begin
      check({nm, "_ram_sel"}, {31'd0, ram_sel}, 32'd0);
      check({nm, "_ram_wen"}, {28'd0, ram_wen}, 32'd0);
    end
    cnt = 1;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!mem_ready && cnt < 8);
    mem_valid = 1'b0;
    check({nm, "_latency"}, cnt, 32'd2);
    check({nm, "_ram_sel_once"}, {31'd0, ram_sel}, 32'd0);
    model_apply(a, wd, ws);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          pulses;
    int          cnt;
    exp_t        e;
    for (int i = 0; i < 512; i++) begin
      ref_mem[i] = 32'd0;
      ram_dev[i] = 32'd0;
    end
    ref_led = 6'd0;
    ref_err = 1'b0;

    // Reset state
    #12;
    check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_ram_sel", {31'd0, ram_sel}, 32'd0);
    check("rst_ram_wen", {28'd0, ram_wen}, 32'd0);
    check("rst_led", {26'd0, led}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // RAM write then read
    xfer(32'h0000_0010, 32'h1234_5678, 4'b1111, "ram_wr10");
    xfer(32'h0000_0010, 32'h0, 4'b0000, "ram_rd10");

    // LED write, readback, ignored strobe
    xfer(LED_ADDR, 32'hFFFF_FF2A, 4'b0001, "led_wr");
    check("led_value", {26'd0, led}, 32'h2A);
    xfer(LED_ADDR, 32'h0, 4'b0000, "led_rd");
    xfer(LED_ADDR, 32'h0000_0015, 4'b0010, "led_wr_b1");
    check("led_unchanged", {26'd0, led}, 32'h2A);

    // Unmapped read
    xfer(32'h4000_0000, 32'h0, 4'b0000, "unmapped_rd");
    check("bus_err_unmapped", {31'd0, bus_err}, {31'd0, ref_err});

    // Window edges
    xfer(32'h0000_07FC, 32'hA5A5_0F0F, 4'b1111, "edge_wr7fc");
    xfer(32'h0000_07FC, 32'h0, 4'b0000, "edge_rd7fc");
    xfer(32'h0000_0000, 32'h0, 4'b0000, "edge_rd000");
    xfer(32'h0000_0800, 32'h0, 4'b0000, "edge_rd800");

    // Randomized traffic
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: a = RAM_BASE | ($urandom_range(0, 511) << 2);
        3:       a = LED_ADDR | {30'd0, 2'($urandom_range(0, 3))};
        default: a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
      endcase
      wd = $urandom;
      ws = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
      xfer(a, wd, ws, "rand");
    end
    check("bus_err_rand", {31'd0, bus_err}, {31'd0, ref_err});

    // mem_valid held for 9 cycles
    @(posedge clk); #1;
    e.chk = 1'b1; e.data = model_rdata(32'h0000_0010); e.name = "held_rd";
    for (int i = 0; i < 3; i++) exp_q.push_back(e);
    mem_valid = 1'b1; mem_addr = 32'h0000_0010; mem_wstrb = 4'd0;
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (mem_ready) pulses++;
    end
    mem_valid = 1'b0;
    check("held_pulses", pulses, 32'd3);

    // Reset during ACCESS of a RAM write
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = 32'h0000_0020; mem_wdata = 32'hCAFE_F00D; mem_wstrb = 4'hF;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    check("abort_ram_sel", {31'd0, ram_sel}, 32'd0);
    check("abort_ram_wen", {28'd0, ram_wen}, 32'd0);
    check("abort_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("abort_led", {26'd0, led}, 32'd0);
    check("abort_bus_err", {31'd0, bus_err}, 32'd0);
    ref_led = 6'd0;
    ref_err = 1'b0;
    mem_valid = 1'b0;
    repeat (2) @(posedge clk);
    // Valid held across reset release becomes a fresh transfer
    mem_valid = 1'b1; mem_addr = LED_ADDR; mem_wstrb = 4'd0;
    e.chk = 1'b1; e.data = 32'd0; e.name = "post_reset_led";
    exp_q.push_back(e);
    @(posedge clk); #1;
    resetn = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!mem_ready && cnt < 8);
    mem_valid = 1'b0;
    check("post_reset_latency", cnt, 32'd2);

    // Restore a known word after the aborted write, then read it
    xfer(32'h0000_0020, 32'h0BAD_CAFE, 4'hF, "restore_wr");
    xfer(32'h0000_0020, 32'h0, 4'h0, "restore_rd");
    xfer(32'h0000_0010, 32'h0, 4'h0, "final_rd10");

    repeat (3) @(posedge clk);
    #1;
    check("final_bus_err", {31'd0, bus_err}, {31'd0, ref_err});
    check("final_led", {26'd0, led}, {26'd0, ref_led});
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
